// File: rtl/aes_pkg.sv
// Shared definitions for the AES input loader: FSM states, byte counts and the
// key-length to round-count / core-latency mapping.
package aes_pkg;

    typedef enum logic [1:0] {FILL, START, BUSY, DONE} state_e;

    localparam int BLOCK_BYTES = 16;

    function automatic int key_bytes(input int nk);
        return nk * 4;
    endfunction

    // AES-128/192/256: NK 4/6/8 -> NR 10/12/14
    function automatic int nk_to_nr(input int nk);
        return nk + 6;
    endfunction

    function automatic int core_latency(input int nr);
        return nr + 2;
    endfunction

endpackage

// File: rtl/aes_byte_packer.sv
// MSB-first byte packer: byte k of a fill lands at byte lane NBYTES-1-k.
// Unwritten lanes keep their previous contents; WRAP returns the count to 0 on the last byte.
module aes_byte_packer
    import aes_pkg::*;
#(
    parameter int NBYTES = BLOCK_BYTES,
    parameter int CW     = 5,
    parameter bit WRAP   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  load_i,
    input  logic [7:0]            byte_i,
    output logic [NBYTES*8-1:0]   data_o,
    output logic [CW-1:0]         cnt_o
);

    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);
    localparam logic [CW-1:0] FULL = CW'(NBYTES);

    logic [NBYTES*8-1:0] data_q, data_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < NBYTES; i++) begin
            if (load_i && cnt_q == CW'(i)) data_d[(NBYTES-1-i)*8 +: 8] = byte_i;
        end
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i && cnt_q != FULL) begin
            cnt_d = (WRAP && cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data_o = data_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/aes_input_loader.sv
// Byte-serial plaintext/key loader in front of the AES core: fills a block and
// key, pulses start, holds operands for the core's latency, then pulses done.
module aes_input_loader
    import aes_pkg::*;
#(
    parameter int NK = 4,
    parameter int NR = nk_to_nr(NK)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_byte,
    input  logic              in_is_key,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [127:0]      data_out,
    output logic [NK*32-1:0]  key_out,
    output logic              key_valid,
    output logic              start,
    output logic              busy,
    output logic              done
);

    localparam int CORE_LATENCY = core_latency(NR);
    localparam int KB           = key_bytes(NK);
    localparam int KW           = NK * 32;
    localparam int LW           = $clog2(CORE_LATENCY + 1);
    localparam logic [KW-1:0] LSB_MASK = KW'(8'hff);

    state_e          state_q, state_d;
    logic [LW-1:0]   lat_q, lat_d;
    logic [KW-1:0]   key_out_q;
    logic            key_valid_q;
    logic [KW-1:0]   shadow;
    logic [4:0]      data_cnt;
    logic [5:0]      key_cnt;
    logic            data_full, acc_data, acc_key, data_last, key_last;

    assign data_full = (data_cnt == 5'(BLOCK_BYTES));
    assign in_ready  = (state_q == FILL) && (in_is_key || !data_full);
    assign acc_data  = in_valid && in_ready && !in_is_key;
    assign acc_key   = in_valid && in_ready && in_is_key;
    assign data_last = acc_data && (data_cnt == 5'(BLOCK_BYTES - 1));
    assign key_last  = acc_key && (key_cnt == 6'(KB - 1));

    aes_byte_packer #(.NBYTES(BLOCK_BYTES), .CW(5), .WRAP(1'b0)) u_data (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q == DONE),
        .load_i (acc_data),
        .byte_i (in_byte),
        .data_o (data_out),
        .cnt_o  (data_cnt)
    );

    // Partial keys live only here; key_out is updated atomically on the last byte.
    aes_byte_packer #(.NBYTES(KB), .CW(6), .WRAP(1'b1)) u_key (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (1'b0),
        .load_i (acc_key),
        .byte_i (in_byte),
        .data_o (shadow),
        .cnt_o  (key_cnt)
    );

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        case (state_q)
            FILL:  if ((data_full || data_last) && (key_valid_q || key_last)) state_d = START;
            START: begin
                state_d = BUSY;
                lat_d   = LW'(1);
            end
            BUSY: begin
                if (lat_q == LW'(CORE_LATENCY - 1)) begin
                    state_d = DONE;
                    lat_d   = '0;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            DONE:    state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            lat_q       <= '0;
            key_out_q   <= '0;
            key_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            if (key_last) begin
                // last key byte always lands in the lowest lane
                key_out_q   <= (shadow & ~LSB_MASK) | KW'(in_byte);
                key_valid_q <= 1'b1;
            end
        end
    end

    assign key_out   = key_out_q;
    assign key_valid = key_valid_q;
    assign start     = (state_q == START);
    assign busy      = (state_q == START) || (state_q == BUSY);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_aes_input_loader.sv
// Directed bench for aes_input_loader: table of full block loads plus hand
// sequences for stalls, partial keys, reset mid-run and the NK=8 variant.
module tb_aes_input_loader;

    logic clk = 1'b0;
    logic rst, in_is_key, in_valid, sel;
    logic [7:0] in_byte;

    logic         r4, kv4, s4, b4, dn4;
    logic [127:0] d4, k4;
    logic         r8, kv8, s8, b8, dn8;
    logic [127:0] d8;
    logic [255:0] k8;

    logic v4, v8, ready_m, start_m, busy_m, done_m;
    assign v4 = in_valid & ~sel;
    assign v8 = in_valid & sel;
    assign ready_m = sel ? r8 : r4;
    assign start_m = sel ? s8 : s4;
    assign busy_m  = sel ? b8 : b4;
    assign done_m  = sel ? dn8 : dn4;

    aes_input_loader #(.NK(4), .NR(10)) u_dut (
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_is_key(in_is_key), .in_valid(v4),
        .in_ready(r4), .data_out(d4), .key_out(k4), .key_valid(kv4),
        .start(s4), .busy(b4), .done(dn4)
    );

    aes_input_loader #(.NK(8), .NR(14)) u_dut8 (
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_is_key(in_is_key), .in_valid(v8),
        .in_ready(r8), .data_out(d8), .key_out(k8), .key_valid(kv8),
        .start(s8), .busy(b8), .done(dn8)
    );

    always #5 clk = ~clk;

    int cyc = 0, start_cnt = 0, done_cnt = 0, start_cyc = 0, done_cyc = 0, bad_ready = 0;
    int nchk = 0, nerr = 0, last_edge = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (start_m) begin start_cnt <= start_cnt + 1; start_cyc <= cyc; end
        if (done_m)  begin done_cnt  <= done_cnt + 1;  done_cyc  <= cyc; end
        if ((start_m || busy_m || done_m) && ready_m) bad_ready <= bad_ready + 1;
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic k);
        in_byte = b; in_is_key = k; in_valid = 1'b1;
        #1;
        chk("send_ready", 256'(ready_m), 256'(1));
        @(posedge clk); #1;
        last_edge = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_start(input int bound);
        int n = 0;
        int s0 = start_cnt;
        while (start_cnt == s0 && n < bound) begin @(negedge clk); #1; n++; end
        chk("start_seen", 256'(start_cnt != s0), 256'(1));
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < bound) begin @(negedge clk); #1; n++; end
        chk("done_seen", 256'(done_cnt != d0), 256'(1));
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic         load_key;
        logic [127:0] key;
        logic [127:0] data;
        logic [127:0] exp_key;
    } vec_t;
    vec_t tbl[3];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", nerr);
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] ka, k2, db, dp, dr;
        logic [255:0] exp8;
        int le, s0, dc;

        tbl[0] = '{1'b1, 128'h000102030405060708090a0b0c0d0e0f,
                   128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f};
        tbl[1] = '{1'b0, 128'h0,
                   128'h0123456789abcdeffedcba9876543210, 128'h000102030405060708090a0b0c0d0e0f};
        tbl[2] = '{1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                   128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c};

        rst = 1'b1; in_valid = 1'b0; in_is_key = 1'b0; in_byte = '0; sel = 1'b0;
        #1;
        chk("rst_data", 256'(d4), 256'(0));
        chk("rst_key", 256'(k4), 256'(0));
        chk("rst_kvalid", 256'(kv4), 256'(0));
        chk("rst_start", 256'(s4), 256'(0));
        chk("rst_busy", 256'(b4), 256'(0));
        chk("rst_done", 256'(dn4), 256'(0));
        chk("rst_ready", 256'(r4), 256'(1));
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Table: full loads, key reuse and key replacement
        for (int r = 0; r < 3; r++) begin
            if (tbl[r].load_key)
                for (int i = 0; i < 16; i++) send(tbl[r].key[127-8*i -: 8], 1'b1);
            for (int i = 0; i < 16; i++) send(tbl[r].data[127-8*i -: 8], 1'b0);
            le = last_edge;
            s0 = start_cnt;
            wait_start(20);
            chk("start_lat", 256'(start_cyc), 256'(le));
            chk("key_out", 256'(k4), 256'(tbl[r].exp_key));
            chk("data_out", 256'(d4), 256'(tbl[r].data));
            chk("key_valid", 256'(kv4), 256'(1));
            wait_done(40);
            chk("done_gap", 256'(done_cyc - start_cyc), 256'(12));
            chk("start_once", 256'(start_cnt - s0), 256'(1));
            chk("data_hold", 256'(d4), 256'(tbl[r].data));
            chk("busy_at_done", 256'(b4), 256'(0));
            chk("ready_busy", 256'(bad_ready), 256'(0));
            next_cycle();
        end

        // Data before key: 17th data byte must stall until the key completes
        rst = 1'b1; next_cycle(); rst = 1'b0; next_cycle();
        db = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
        ka = 128'hdeadbeef0123456789abcdeffedcba98;
        for (int i = 0; i < 16; i++) send(db[127-8*i -: 8], 1'b0);
        s0 = start_cnt;
        in_byte = 8'haa; in_is_key = 1'b0; in_valid = 1'b1;
        #1 chk("stall_ready", 256'(r4), 256'(0));
        repeat (3) next_cycle();
        chk("stall_ready2", 256'(r4), 256'(0));
        chk("stall_data", 256'(d4), 256'(db));
        chk("stall_nostart", 256'(start_cnt), 256'(s0));
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) send(ka[127-8*i -: 8], 1'b1);
        le = last_edge;
        wait_start(20);
        chk("dbk_start_lat", 256'(start_cyc), 256'(le));
        chk("dbk_key", 256'(k4), 256'(ka));
        chk("dbk_data", 256'(d4), 256'(db));
        wait_done(40);
        chk("dbk_done_gap", 256'(done_cyc - start_cyc), 256'(12));
        next_cycle();

        // Partial key survives a block; old key used until it completes
        k2 = 128'h8899aabbccddeeff0011223344556677;
        dp = 128'h0123456789abcdef0123456789abcdef;
        for (int i = 0; i < 8; i++) send(k2[127-8*i -: 8], 1'b1);
        chk("partial_hold", 256'(k4), 256'(ka));
        for (int i = 0; i < 16; i++) send(dp[127-8*i -: 8], 1'b0);
        wait_start(20);
        chk("partial_start_key", 256'(k4), 256'(ka));
        wait_done(40);
        next_cycle();
        for (int i = 8; i < 16; i++) send(k2[127-8*i -: 8], 1'b1);
        chk("partial_done_key", 256'(k4), 256'(k2));

        // Reset during BUSY aborts the block
        dr = 128'h00000000ffffffff00000000ffffffff;
        for (int i = 0; i < 16; i++) send(dr[127-8*i -: 8], 1'b0);
        wait_start(20);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", 256'(b4), 256'(0));
        chk("abort_done", 256'(dn4), 256'(0));
        chk("abort_kvalid", 256'(kv4), 256'(0));
        chk("abort_key", 256'(k4), 256'(0));
        chk("abort_data", 256'(d4), 256'(0));
        dc = done_cnt;
        repeat (3) next_cycle();
        rst = 1'b0;
        repeat (20) next_cycle();
        chk("abort_no_done", 256'(done_cnt), 256'(dc));
        chk("abort_ready", 256'(r4), 256'(1));

        // NK=8 / NR=14 variant
        sel = 1'b1;
        exp8 = '0;
        for (int i = 0; i < 32; i++) exp8[255-8*i -: 8] = 8'(i);
        for (int i = 0; i < 32; i++) send(8'(i), 1'b1);
        for (int i = 0; i < 16; i++) send(db[127-8*i -: 8], 1'b0);
        le = last_edge;
        wait_start(20);
        chk("nk8_start_lat", 256'(start_cyc), 256'(le));
        chk("nk8_key", k8, exp8);
        chk("nk8_data", 256'(d8), 256'(db));
        wait_done(40);
        chk("nk8_done_gap", 256'(done_cyc - start_cyc), 256'(16));
        chk("nk8_ready_busy", 256'(bad_ready), 256'(0));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/aes_input_loader.md
Name: aes_input_loader

Overview:
Byte-serial front end that sits directly upstream of the AES encryption core. It assembles a 128-bit plaintext block and an Nk*32-bit cipher key from a valid/ready byte stream. It presents both to the core with a one-cycle start pulse and holds them stable for the core's full round sequence. It then pulses done, so a downstream stage can sample the core output, and reopens for the next block.

Parameters:
- NK, 4, key length in 32-bit words (4/6/8); key is NK*4 bytes.
- NR, 10, round count of the attached core (10/12/14).
- CORE_LATENCY, NR+2, cycles the core needs from start until its output is final. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_byte  in  8  stream byte.
- in_is_key  in  1  1 = in_byte is a key byte; 0 = plaintext byte. Qualified by in_valid.
- in_valid  in  1  byte present.
- in_ready  out  1  loader accepts the byte this cycle. Transfer occurs when in_valid && in_ready.
- data_out  out  128  assembled plaintext block to core.
- key_out  out  NK*32  assembled key to core.
- key_valid  out  1  a complete key has been loaded since reset.
- start  out  1  one-cycle pulse; core samples data_out/key_out on this cycle.
- busy  out  1  core running; data_out/key_out frozen.
- done  out  1  one-cycle pulse; core output valid this cycle.

Behaviour:
- Reset (async assert, sync release): state=FILL, counters 0, data_out=0, key_out=0, shadow key=0, key_valid=0, start=0, busy=0, done=0.
- Byte order, MSB-first:
  - First data byte lands in data_out[127:120]; 16th byte lands in [7:0].
  - First key byte lands in key[NK*32-1 : NK*32-8].
- Counters:
  - data_cnt is 0..16, 5 bits. data_full = (data_cnt==16).
  - key_cnt is 0..NK*4, 6 bits.
- Key path:
  - Key bytes fill a shadow register.
  - On acceptance of byte NK*4, the shadow value (including that byte) is copied into key_out on the same edge; key_cnt→0, key_valid→1.
  - key_out changes only on that edge. A partial key never reaches key_out.
  - The key persists across blocks until a new complete key is loaded.
- in_ready (combinational):
  - 1 only in FILL, and then gated per byte type.
  - Key bytes: always ready in FILL.
  - Data bytes: ready iff !data_full.
  - 0 in START, BUSY and DONE.
- FSM:
  - FILL: accept bytes. Go to START on the edge where data_full && key_valid becomes true. This covers:
    - last data byte accepted while key_valid=1;
    - last key byte completing while data_full=1.
    - Either event → START next cycle.
  - If data_full && !key_valid: remain in FILL; data bytes stalled, key bytes accepted.
  - START (1 cycle): start=1, busy=1. Latency: last enabling byte at edge N → start high in cycle N+1.
  - BUSY: busy=1; lat_cnt counts 1..CORE_LATENCY-1 (start cycle counts as first). On reaching it → DONE.
  - DONE (1 cycle): done=1, busy=0; data_cnt→0 → FILL.
  - Total start-to-done spacing = CORE_LATENCY cycles. With defaults, start at cycle T gives done at T+12.
- data_out holds the last block through DONE. It is overwritten only byte-wise during the next fill.
- Interleaving key and data bytes within a fill is legal; counters are independent.
- A partial key in the shadow register when START fires is retained; its bytes continue to fill on the next FILL.
- Reset mid-BUSY aborts the block: no done, key_valid=0, all cleared.

Decomposition:
- Shared package aes_pkg holds:
  - state enum {FILL, START, BUSY, DONE};
  - the NK→NR mapping function;
  - the CORE_LATENCY derivation;
  - the byte-count constants BLOCK_BYTES=16 and KEY_BYTES(NK).
- One sub-module is natural: aes_byte_packer (parameterised width, MSB-first shift/insert with count and full flag), instantiated twice, for data and for the shadow key.

Test Plan:
- Key-then-data, NK=4, no stalls:
  - Stimulus: key bytes 00..0f, then data bytes 00,11,22,...,ff.
  - Response: key_out=000102030405060708090a0b0c0d0e0f, key_valid=1; data_out=00112233445566778899aabbccddeeff; start one cycle after the 16th data byte; done exactly 12 cycles after start; in_ready=0 from start through done.
- Data before key:
  - Stimulus: 16 data bytes, then a 17th data byte offered with in_valid=1, then 16 key bytes.
  - Response: in_ready=0 for the 17th byte; data_out unchanged; start one cycle after the last key byte.
- Key reuse:
  - Stimulus: after done, send only 16 data bytes.
  - Response: start issued; key_out unchanged from the previous load.
- Partial key update:
  - Stimulus: send 8 key bytes, then 16 data bytes.
  - Response: start uses the old key_out; after done, the remaining 8 key bytes complete and update key_out.
- NK=8, NR=14:
  - Stimulus: 32 key bytes 00..1f, then a block.
  - Response: key_out=000102...1f; done 16 cycles after start.
- Reset mid-BUSY:
  - Stimulus: assert rst 5 cycles after start.
  - Response: busy, done, key_valid and counters 0 immediately on assert; no done pulse; in_ready=1 after release.
